// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine-timer access controller: FSM states,
// timer register map and the safe compare-high value used during updates.
package mtimer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_HMAX = 3'd1,
    W_LO   = 3'd2,
    W_HI   = 3'd3,
    R_HI1  = 3'd4,
    R_LO   = 3'd5,
    R_HI2  = 3'd6,
    RESP   = 3'd7
  } state_t;

  localparam logic [1:0]  ADDR_TIME_LO = 2'b00;
  localparam logic [1:0]  ADDR_TIME_HI = 2'b01;
  localparam logic [1:0]  ADDR_CMP_LO  = 2'b10;
  localparam logic [1:0]  ADDR_CMP_HI  = 2'b11;

  localparam logic [31:0] CMP_HI_SAFE  = 32'hFFFF_FFFF;

endpackage

// File: rtl/mtimer_ctrl.sv
// Sequences glitch-free 64-bit compare writes and torn-read-safe mtime reads
// over a 32-bit timer port. Optional macro MTIMER_CTRL_IRQ_MASK_EN masks irq
// while the compare value is being rewritten.
//
// state  | meaning
// IDLE   | waiting for a cmp or rd request (cmp has priority)
// W_HMAX | park compare hi at all-ones so no spurious match during update
// W_LO   | write compare lo
// W_HI   | write compare hi
// R_HI1  | sample mtime hi
// R_LO   | sample mtime lo
// R_HI2  | re-sample hi; equal -> done, else retry lo or give up with error
// RESP   | hold read response until accepted
module mtimer_ctrl
  import mtimer_pkg::*;
#(
  parameter int RETRY_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmp_valid,
  output logic        cmp_ready,
  input  logic [63:0] cmp_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  output logic        rd_resp_valid,
  input  logic        rd_resp_ready,
  output logic [63:0] rd_resp_data,
  output logic        rd_resp_err,
  output logic [1:0]  t_addr,
  output logic        t_we,
  output logic [31:0] t_din,
  input  logic [31:0] t_dout,
  input  logic        t_irq,
  output logic        irq,
  output logic        busy
);

  localparam int CNT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(RETRY_MAX);

  state_t           state, state_nxt;
  logic [63:0]      cmp_q;
  logic [31:0]      hi1_q, lo_q;
  logic             err_q;
  logic [CNT_W-1:0] retry_q;
  logic             cmp_acc, rd_acc, hi_match, retry_done;

  // Ready lines are gated by rst_n so every output reads 0 while held in reset.
  assign cmp_ready  = (state == IDLE) && rst_n;
  assign rd_ready   = (state == IDLE) && !cmp_valid && rst_n;
  assign cmp_acc    = cmp_valid && cmp_ready;
  assign rd_acc     = rd_valid && rd_ready;
  assign hi_match   = (t_dout == hi1_q);
  assign retry_done = (retry_q == RETRY_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    t_addr    = ADDR_TIME_LO;
    t_we      = 1'b0;
    t_din     = 32'h0;
    case (state)
      IDLE: begin
        if (cmp_acc)     state_nxt = W_HMAX;
        else if (rd_acc) state_nxt = R_HI1;
      end
      W_HMAX: begin
        t_addr    = ADDR_CMP_HI;
        t_we      = 1'b1;
        t_din     = CMP_HI_SAFE;
        state_nxt = W_LO;
      end
      W_LO: begin
        t_addr    = ADDR_CMP_LO;
        t_we      = 1'b1;
        t_din     = cmp_q[31:0];
        state_nxt = W_HI;
      end
      W_HI: begin
        t_addr    = ADDR_CMP_HI;
        t_we      = 1'b1;
        t_din     = cmp_q[63:32];
        state_nxt = IDLE;
      end
      R_HI1: begin
        t_addr    = ADDR_TIME_HI;
        state_nxt = R_LO;
      end
      R_LO: begin
        t_addr    = ADDR_TIME_LO;
        state_nxt = R_HI2;
      end
      R_HI2: begin
        t_addr = ADDR_TIME_HI;
        if (hi_match || retry_done) state_nxt = RESP;
        else                        state_nxt = R_LO;
      end
      RESP: begin
        if (rd_resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q   <= 64'h0;
      hi1_q   <= 32'h0;
      lo_q    <= 32'h0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmp_acc) begin
            cmp_q   <= cmp_data;
            retry_q <= '0;
          end else if (rd_acc) begin
            err_q   <= 1'b0;
            retry_q <= '0;
          end
        end
        R_HI1: hi1_q <= t_dout;
        R_LO:  lo_q  <= t_dout;
        R_HI2: begin
          // On mismatch hi1 tracks the newest hi so a retry compares against it
          // and an error response reports it.
          if (!hi_match) begin
            hi1_q <= t_dout;
            if (retry_done) err_q   <= 1'b1;
            else            retry_q <= retry_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_resp_valid = (state == RESP);
  assign rd_resp_data  = (state == RESP) ? {hi1_q, lo_q} : 64'h0;
  assign rd_resp_err   = (state == RESP) && err_q;
  assign busy          = (state != IDLE);

`ifdef MTIMER_CTRL_IRQ_MASK_EN
  assign irq = t_irq && rst_n && !((state == W_HMAX) || (state == W_LO) || (state == W_HI));
`else
  assign irq = t_irq && rst_n;
`endif

endmodule

// File: tb/tb_mtimer_ctrl.sv
// Self-checking bench for mtimer_ctrl: behavioural timer model, directed and
// randomized compare writes and atomic reads against a loop-level read model.
module tb_mtimer_ctrl;

  localparam int RETRY_MAX = 3;
`ifdef MTIMER_CTRL_IRQ_MASK_EN
  localparam bit IRQ_MASK = 1'b1;
`else
  localparam bit IRQ_MASK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmp_valid = 1'b0;
  logic        cmp_ready;
  logic [63:0] cmp_data = 64'h0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic        rd_resp_valid;
  logic        rd_resp_ready = 1'b0;
  logic [63:0] rd_resp_data;
  logic        rd_resp_err;
  logic [1:0]  t_addr;
  logic        t_we;
  logic [31:0] t_din;
  logic [31:0] t_dout;
  logic        t_irq = 1'b0;
  logic        irq;
  logic        busy;

  mtimer_ctrl #(.RETRY_MAX(RETRY_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_data(cmp_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
    .t_addr(t_addr), .t_we(t_we), .t_din(t_din), .t_dout(t_dout),
    .t_irq(t_irq), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  // Timer model: mtime as a function of how many hi reads this read has made.
  // mode 0 stable, mode 1 ticks +1 after the first hi read, mode 2 hi changes on every hi read.
  logic [63:0] mtime = 64'h0;
  int          mode = 0;
  int          rd_base = 0;
  int          hi_reads = 0;
  logic [63:0] tcmp = 64'h0;
  logic [63:0] mt_now;

  function automatic logic [63:0] mt_at(input int md, input logic [63:0] base, input int k);
    case (md)
      1:       return (k >= 1) ? base + 64'd1 : base;
      2:       return {base[63:32] + 32'(k), base[31:0]};
      default: return base;
    endcase
  endfunction

  always_comb mt_now = mt_at(mode, mtime, hi_reads - rd_base);

  always_comb begin
    case (t_addr)
      2'b00:   t_dout = mt_now[31:0];
      2'b01:   t_dout = mt_now[63:32];
      2'b10:   t_dout = tcmp[31:0];
      default: t_dout = tcmp[63:32];
    endcase
  end

  always @(posedge clk) begin
    if (t_we && t_addr == 2'b10) tcmp[31:0]  <= t_din;
    if (t_we && t_addr == 2'b11) tcmp[63:32] <= t_din;
    if (!t_we && t_addr == 2'b01) hi_reads <= hi_reads + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read model: hi, lo, hi again; retry lo/hi up to RETRY_MAX times.
  task automatic model_read(input int md, input logic [63:0] base,
                            output logic [63:0] d, output logic e, output int lat);
    logic [63:0] v;
    logic [31:0] h, h2, l;
    int k;
    v = mt_at(md, base, 0);
    h = v[63:32];
    k = 1;
    d = 64'h0; e = 1'b0; lat = 0;
    for (int m = 0; m <= RETRY_MAX; m++) begin
      v  = mt_at(md, base, k);
      l  = v[31:0];
      h2 = v[63:32];
      k++;
      if (h2 == h) begin
        d = {h, l}; lat = 4 + 2 * m; return;
      end
      if (m == RETRY_MAX) begin
        d = {h2, l}; e = 1'b1; lat = 4 + 2 * m; return;
      end
      h = h2;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_outs"}, {57'h0, cmp_ready, rd_ready, rd_resp_valid, rd_resp_err, t_we, irq, busy}, 64'h0);
    check({tag, "_data"}, rd_resp_data, 64'h0);
    check({tag, "_taddr_din"}, {30'h0, t_addr, t_din}, 64'h0);
  endtask

  task automatic do_cmp(input logic [63:0] data, input logic irq_in);
    logic [1:0]  ea [3];
    logic [31:0] ed [3];
    ea[0] = 2'b11; ed[0] = 32'hFFFF_FFFF;
    ea[1] = 2'b10; ed[1] = data[31:0];
    ea[2] = 2'b11; ed[2] = data[63:32];
    t_irq = irq_in;
    check("cmp_ready_idle", cmp_ready, 1);
    cmp_valid = 1'b1; cmp_data = data;
    @(negedge clk);
    cmp_valid = 1'b0; cmp_data = ~data;
    for (int i = 0; i < 3; i++) begin
      check("w_we", t_we, 1);
      check("w_addr", t_addr, ea[i]);
      check("w_din", t_din, ed[i]);
      check("w_busy_noready", {busy, cmp_ready, rd_ready}, 3'b100);
      check("w_irq", irq, irq_in && !IRQ_MASK);
      @(negedge clk);
    end
    check("cmp_ready_back", {cmp_ready, t_we, busy}, 3'b100);
    check("cmp_written", tcmp, data);
    t_irq = 1'b0;
  endtask

  task automatic do_rd(input int md, input logic [63:0] base, input int delay);
    logic [63:0] ed;
    logic        ee;
    int          lat, cnt;
    mode = md; mtime = base; rd_base = hi_reads;
    model_read(md, base, ed, ee, lat);
    check("rd_ready_idle", rd_ready, 1);
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    cnt = 1;
    while (!rd_resp_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("rd_latency", 64'(cnt), 64'(lat));
    check("rd_data", rd_resp_data, ed);
    check("rd_err", rd_resp_err, ee);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("resp_hold", {rd_resp_valid, rd_resp_err, busy}, {1'b1, ee, 1'b1});
      check("resp_hold_data", rd_resp_data, ed);
    end
    rd_resp_ready = 1'b1;
    @(negedge clk);
    rd_resp_ready = 1'b0;
    check("resp_done", {rd_resp_valid, busy, rd_ready}, 3'b001);
  endtask

  initial begin
    logic [63:0] r;
    int md;

    // Reset with every input active
    t_irq = 1'b1; cmp_valid = 1'b1; rd_valid = 1'b1; rd_resp_ready = 1'b1;
    cmp_data = 64'h1234_5678_9ABC_DEF0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    cmp_valid = 1'b0; rd_valid = 1'b0; rd_resp_ready = 1'b0; t_irq = 1'b0;
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {cmp_ready, rd_ready, busy}, 3'b110);
    @(negedge clk);

    t_irq = 1'b1; #1;
    check("irq_pass_hi", irq, 1);
    t_irq = 1'b0; #1;
    check("irq_pass_lo", irq, 0);
    @(negedge clk);

    do_cmp(64'h0000_0005_0000_0010, 1'b0);
    do_cmp({$urandom, $urandom}, 1'b1);

    // Simultaneous cmp and rd: cmp first, rd accepted when cmp_ready returns
    r = {$urandom, $urandom};
    cmp_valid = 1'b1; rd_valid = 1'b1; cmp_data = r;
    #1;
    check("both_rd_ready_low", {cmp_ready, rd_ready}, 2'b10);
    @(negedge clk);
    cmp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("both_writes", {t_we, rd_ready}, 2'b10);
      @(negedge clk);
    end
    check("both_rd_ready_back", rd_ready, 1);
    mode = 0; mtime = 64'h0000_00AB_CDEF_0123; rd_base = hi_reads;
    @(negedge clk);
    rd_valid = 1'b0;
    check("both_rd_hi1", {busy, t_addr}, 3'b101);
    repeat (3) @(negedge clk);
    check("both_resp", {rd_resp_valid, rd_resp_err}, 2'b10);
    check("both_resp_data", rd_resp_data, 64'h0000_00AB_CDEF_0123);
    check("both_cmp_written", tcmp, r);
    rd_resp_ready = 1'b1;
    @(negedge clk);
    rd_resp_ready = 1'b0;

    do_rd(0, 64'h0000_0001_0000_002A, 0);
    do_rd(1, 64'h0000_0003_FFFF_FFFF, 1);
    do_rd(2, {$urandom, $urandom}, 3);

    for (int it = 0; it < 8; it++) begin
      do_cmp({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      md = $urandom_range(0, 2);
      r = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) r[31:0] = 32'hFFFF_FFFF;
      do_rd(md, r, $urandom_range(0, 3));
    end

    // Reset pulse during W_LO
    t_irq = 1'b1;
    r = {$urandom, $urandom};
    cmp_valid = 1'b1; cmp_data = r;
    @(negedge clk);
    cmp_valid = 1'b0;
    check("abort_whmax_irq", irq, !IRQ_MASK);
    @(negedge clk);
    check("abort_in_wlo", {t_we, t_addr}, 3'b110);
    check("abort_wlo_irq", irq, !IRQ_MASK);
    rst_n = 1'b0;
    #1;
    check_quiet("abort_reset");
    check("abort_cmp_hi_safe", tcmp[63:32], 32'hFFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1; t_irq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_write", {t_we, busy, rd_resp_valid}, 3'b000);
      @(negedge clk);
    end
    check("abort_cmp_hi_kept", tcmp[63:32], 32'hFFFF_FFFF);

    do_rd(0, {$urandom, $urandom}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
